// File: rtl/add1x1_pkg.sv
`default_nettype none
// ============================================================================
// add1x1_pkg : shared constants and result type for the 1x1 bit-serial adder
// Rev 1.0
// ============================================================================
package add1x1_pkg;

  localparam int c_REG_OUT_DEFAULT = 1;

  typedef struct packed {
    logic co;
    logic sum;
  } result_t;

  function automatic result_t pack_result(input logic co, input logic sum);
    result_t r;
    r.co  = co;
    r.sum = sum;
    return r;
  endfunction

endpackage : add1x1_pkg
`default_nettype wire

// File: rtl/add1x1_if.sv
`default_nettype none
// ============================================================================
// add1x1_if : operand/result bundle of the bit-serial adder
// Rev 1.0
// ============================================================================
interface add1x1_if;
  import add1x1_pkg::*;

  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic first;
  logic sum;
  logic co;
  logic out_valid;

  modport master (
    output a, b, cin, in_valid, first,
    input  sum, co, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid, first,
    output sum, co, out_valid
  );

endinterface : add1x1_if
`default_nettype wire

// File: rtl/add1x1_fa_core.sv
`default_nettype none
// ============================================================================
// fa_core : purely combinational one-bit full adder
// Rev 1.0
// ============================================================================
module fa_core (
  input  wire logic a,
  input  wire logic b,
  input  wire logic c,
  output logic      s,
  output logic      co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule : fa_core
`default_nettype wire

// File: rtl/add1x1.sv
`default_nettype none
// ============================================================================
// add1x1 : bit-serial adder, one operand bit per cycle, LSB first
// Rev 1.0
// ============================================================================
module add1x1
  import add1x1_pkg::*;
#(
  parameter int REG_OUT = c_REG_OUT_DEFAULT
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  add1x1_if.slave    bus
);

  logic    r_carry_q;
  logic    w_c_eff;
  logic    w_s;
  logic    w_c;
  result_t w_res;

  // A mux rather than gating keeps an unknown carry_q out of a word's first bit.
  assign w_c_eff = bus.first ? bus.cin : r_carry_q;

  fa_core u_fa_core (
    .a  (bus.a),
    .b  (bus.b),
    .c  (w_c_eff),
    .s  (w_s),
    .co (w_c)
  );

  assign w_res = pack_result(w_c, w_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry_q <= 1'b0;
    end else if (bus.in_valid) begin
      r_carry_q <= w_res.co;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      result_t r_res;
      logic    r_out_valid;

      // Result bits hold across idle cycles; only the qualifier drops.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_res       <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= bus.in_valid;
          if (bus.in_valid) begin
            r_res <= w_res;
          end
        end
      end

      assign bus.sum       = r_res.sum;
      assign bus.co        = r_res.co;
      assign bus.out_valid = r_out_valid;
    end else begin : g_comb_out
      assign bus.sum       = w_res.sum;
      assign bus.co        = w_res.co;
      assign bus.out_valid = bus.in_valid;
    end
  endgenerate

endmodule : add1x1
`default_nettype wire

// File: tb/tb_add1x1.sv
`default_nettype none
// ============================================================================
// tb_add1x1 : drives a registered and a combinational add1x1 in lockstep
// Rev 1.0
// ============================================================================
module tb_add1x1;
  import add1x1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  add1x1_if if_reg ();
  add1x1_if if_cmb ();

  add1x1 #(.REG_OUT(1)) u_dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_reg)
  );

  add1x1 #(.REG_OUT(0)) u_dut_cmb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_cmb)
  );

  int   compared   = 0;
  int   mismatched = 0;

  // Reference state: carry as an integer bit, last registered result.
  bit   m_known = 1'b0;
  bit   m_carry = 1'b0;
  logic m_sum   = 1'b0;
  logic m_co    = 1'b0;
  logic m_ov    = 1'b0;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed {ov,co,sum}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic v, input logic f,
                      input logic a, input logic b, input logic ci);
    int   total;
    bit   ceff;
    logic es;
    logic ec;
    bit   computable;

    rst_n           = rn;
    if_reg.in_valid = v;   if_cmb.in_valid = v;
    if_reg.first    = f;   if_cmb.first    = f;
    if_reg.a        = a;   if_cmb.a        = a;
    if_reg.b        = b;   if_cmb.b        = b;
    if_reg.cin      = ci;  if_cmb.cin      = ci;
    #2;

    computable = m_known && !$isunknown({f, a, b}) && (f ? !$isunknown(ci) : 1'b1);
    es = 1'b0;
    ec = 1'b0;
    if (computable) begin
      ceff  = f ? bit'(ci) : m_carry;
      total = int'(a) + int'(b) + int'(ceff);
      es    = (total % 2) == 1;
      ec    = (total / 2) == 1;
      if (!$isunknown(v)) begin
        check({tag, "/comb"}, {if_cmb.out_valid, if_cmb.co, if_cmb.sum}, {v, ec, es});
      end
    end

    if (!rn) begin
      m_carry = 1'b0; m_sum = 1'b0; m_co = 1'b0; m_ov = 1'b0;
      m_known = 1'b1;
    end else if (v) begin
      m_carry = ec; m_sum = es; m_co = ec; m_ov = 1'b1;
    end else begin
      m_ov = 1'b0;
    end

    @(posedge clk);
    #1;
    if (m_known) begin
      check({tag, "/reg"}, {if_reg.out_valid, if_reg.co, if_reg.sum}, {m_ov, m_co, m_sum});
    end
  endtask

  initial begin
    logic [2:0] combo;

    // Reset with garbage operands and no valid.
    step("reset0", 1'b0, 1'b0, 1'bx, 1'bx, 1'bx, 1'bx);
    step("reset1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("idle_x", 1'b1, 1'b0, 1'bx, 1'bx, 1'bx, 1'bx);
    step("idle_x2", 1'b1, 1'b0, 1'b0, 1'bx, 1'b1, 1'bx);

    step("single_100", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Every (a,b,cin) combination as an independent single-bit add.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      step($sformatf("truth_%0d", i), 1'b1, 1'b1, 1'b1, combo[2], combo[1], combo[0]);
    end

    // 3 + 1 serially, LSB first, with an idle gap before the MSB.
    step("ser_b0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("ser_gap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step("ser_b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ser_b2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'bx);

    // Restart mid-word: first=1 discards the stored carry.
    step("restart_a", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("restart_b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-word with carry set, reset beats in_valid.
    step("mid_c1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("mid_after", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // cin unknown while first=0 must not matter.
    step("cinx_a", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("cinx_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'bx);
    step("cinx_c", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'bx);

    for (int n = 0; n < 300; n++) begin
      step("rand",
           logic'($urandom_range(0, 24) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_add1x1
`default_nettype wire

// File: doc/add1x1.md
ADD1X1 -- requirements
Module: add1x1

Interface
REQ-001 Parameter: REG_OUT, default 1, meaning 1 = registered outputs (1-cycle latency), 0 = combinational sum/co with out_valid = in_valid.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  1  addend bit.
REQ-005 b  input  1  addend bit.
REQ-006 cin  input  1  external carry-in, used only when first=1.
REQ-007 in_valid  input  1  operand bits valid this cycle.
REQ-008 first  input  1  marks the LSB (first bit) of a bit-serial word; a single-bit add uses first=1.
REQ-009 sum  output  1  sum bit.
REQ-010 co  output  1  carry-out bit.
REQ-011 out_valid  output  1  sum/co valid qualifier.

Function
REQ-012 Effective carry c_eff SHALL be cin when first=1, else the internal carry register carry_q.
REQ-013 Core SHALL compute s = a XOR b XOR c_eff and c = (a AND b) OR (a AND c_eff) OR (b AND c_eff).
REQ-014 When in_valid=1 at a rising clk edge, carry_q SHALL load c.
REQ-015 With REG_OUT=1: when in_valid=1 at a rising clk edge, sum<=s, co<=c, out_valid<=1; latency exactly 1 cycle.
REQ-016 With REG_OUT=1: when in_valid=0, sum and co SHALL hold their previous values and out_valid<=0.
REQ-017 With REG_OUT=0: sum=s, co=c, out_valid=in_valid combinationally; only carry_q is registered.
REQ-018 When in_valid=0, carry_q SHALL hold; first is ignored.
REQ-019 first=1 mid-word SHALL restart the word: cin is used and the old carry_q is discarded.
REQ-020 When first=1, an X on carry_q SHALL NOT propagate; when first=0, cin SHALL NOT affect any output.
REQ-021 Back-to-back in_valid cycles SHALL be accepted at one bit per cycle; no back-pressure.

Reset
REQ-022 While rst_n=0 at a rising clk edge: sum=0, co=0, out_valid=0, carry_q=0.
REQ-023 Reset SHALL take priority over in_valid in the same cycle; a reset mid-word clears the carry, and the next word requires first=1 for defined cin behaviour (with first=0 the carry used is 0).
REQ-024 No output SHALL change asynchronously on rst_n.

Structure
REQ-025 A shared package SHALL hold the REG_OUT default constant and a 2-bit {co,sum} result typedef.
REQ-026 The combinational full-adder equations SHALL be a sub-module fa_core (a, b, c -> s, co), instantiated once.
REQ-027 carry_q and the output registers SHALL live in add1x1; no latches, no other state.

Verification
REQ-028 first=1, in_valid=1: (a,b,cin)=(1,0,0) -> next cycle sum=1, co=0, out_valid=1.
REQ-029 first=1 each cycle, back-to-back: (1,1,0) -> sum=0, co=1; (1,0,1) -> sum=0, co=1; (0,0,0) -> sum=0, co=0; all 8 combinations match the truth table.
REQ-030 Serial 3+1, LSB first: (a,b,first)=(1,1,1), cin=0, then (1,0,0) -> outputs sum=0, co=1, then sum=0, co=1 (result 100b).
REQ-031 in_valid=0 gap between serial bits -> sum/co held, out_valid=0, carry preserved; the next bit uses the stored carry.
REQ-032 rst_n=0 for one cycle mid-word, with carry_q=1 -> all outputs 0; the next bit with first=0, a=1, b=0 gives sum=1, co=0.
REQ-033 cin=X with first=0, or X before the first valid bit -> outputs remain defined and out_valid=0 until the first valid bit.
